// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper: real-time clock core.
// A prescaler divides clk down to a one-second tick that advances a
// 24-hour HH:MM:SS time. The block also provides a range-checked time load
// port, an HH:MM alarm, a day-wrap pulse and a 12-hour display view of the hours.
module rtc_timekeeper #(
  parameter int TICKS_PER_SEC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       load,
  input  logic [4:0] ld_hrs,
  input  logic [5:0] ld_min,
  input  logic [5:0] ld_sec,
  input  logic       mode12,
  input  logic       alarm_en,
  input  logic [4:0] alm_hrs,
  input  logic [5:0] alm_min,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hrs,
  output logic [4:0] disp_hrs,
  output logic       pm,
  output logic       tick_1hz,
  output logic       day_wrap,
  output logic       alarm,
  output logic       load_err
);

  // The prescaler is at least one bit wide, so TICKS_PER_SEC = 1 still
  // builds. In that case it stays at zero and every running cycle is a tick.
  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICKS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic          sec_tick;
  logic          ld_valid;
  logic [5:0]    nxt_sec;
  logic [5:0]    nxt_min;
  logic [4:0]    nxt_hrs;
  logic          nxt_midnight;
  logic          alm_hit;

  assign sec_tick = run && (presc == PRESC_MAX);
  assign ld_valid = (ld_hrs < 5'd24) && (ld_min < 6'd60) && (ld_sec < 6'd60);

  // Compute the time one second ahead, with carries from seconds to minutes to hours.
  always_comb begin
    nxt_sec = sec;
    nxt_min = min;
    nxt_hrs = hrs;
    if (sec == 6'd59) begin
      nxt_sec = 6'd0;
      if (min == 6'd59) begin
        nxt_min = 6'd0;
        if (hrs == 5'd23) begin
          nxt_hrs = 5'd0;
        end else begin
          nxt_hrs = hrs + 5'd1;
        end
      end else begin
        nxt_min = min + 6'd1;
      end
    end else begin
      nxt_sec = sec + 6'd1;
    end
  end

  // The alarm matches against the advanced time. That time is always in
  // range, so an out-of-range alarm setting can never match.
  assign nxt_midnight = (nxt_hrs == 5'd0) && (nxt_min == 6'd0) && (nxt_sec == 6'd0);
  assign alm_hit      = alarm_en && (nxt_hrs == alm_hrs) && (nxt_min == alm_min) &&
                        (nxt_sec == 6'd0);

  // Prescaler, timekeeping, load handling and event pulses.
  // If a load and a tick fall on the same edge, the load wins and the tick is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      sec      <= 6'd0;
      min      <= 6'd0;
      hrs      <= 5'd0;
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
      alarm    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      day_wrap <= 1'b0;
      alarm    <= 1'b0;
      if (load) begin
        if (ld_valid) begin
          sec      <= ld_sec;
          min      <= ld_min;
          hrs      <= ld_hrs;
          presc    <= '0;
          load_err <= 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (sec_tick) begin
        presc    <= '0;
        sec      <= nxt_sec;
        min      <= nxt_min;
        hrs      <= nxt_hrs;
        tick_1hz <= 1'b1;
        day_wrap <= nxt_midnight;
        alarm    <= alm_hit;
      end else if (run) begin
        presc <= presc + PW'(1);
      end
    end
  end

  // 12-hour view derived from the registered 24-hour hours:
  // hour 0 shows as 12, and hours 13..23 show as 1..11.
  always_comb begin
    disp_hrs = hrs;
    pm       = 1'b0;
    if (mode12) begin
      pm = (hrs >= 5'd12);
      if (hrs == 5'd0) begin
        disp_hrs = 5'd12;
      end else if (hrs > 5'd12) begin
        disp_hrs = hrs - 5'd12;
      end
    end
  end

endmodule

// File: tb/tb_rtc_timekeeper.sv
// tb_rtc_timekeeper: randomized and directed checks of rtc_timekeeper
// against a seconds-of-day reference model. Two instances share all inputs:
// one with a 4-cycle second and one with a 1-cycle second.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       rst, run, load, mode12, alarm_en;
  logic [4:0] ld_hrs, alm_hrs;
  logic [5:0] ld_min, ld_sec, alm_min;

  logic [5:0] sec0, min0, sec1, min1;
  logic [4:0] hrs0, disp0, hrs1, disp1;
  logic       pm0, tick0, wrap0, alarm0, err0;
  logic       pm1, tick1, wrap1, alarm1, err1;
  logic [26:0] got0, got1;

  int checks = 0;
  int errors = 0;

  // Reference model state. The time is held as seconds since midnight.
  int tps [2] = '{4, 1};
  int m_tod [2];
  int m_cnt [2];
  bit m_tick [2];
  bit m_wrap [2];
  bit m_alm [2];
  bit m_err [2];

  rtc_timekeeper #(.TICKS_PER_SEC(4)) dut (
    .clk(clk), .rst(rst), .run(run), .load(load), .ld_hrs(ld_hrs), .ld_min(ld_min),
    .ld_sec(ld_sec), .mode12(mode12), .alarm_en(alarm_en), .alm_hrs(alm_hrs),
    .alm_min(alm_min), .sec(sec0), .min(min0), .hrs(hrs0), .disp_hrs(disp0), .pm(pm0),
    .tick_1hz(tick0), .day_wrap(wrap0), .alarm(alarm0), .load_err(err0)
  );

  rtc_timekeeper #(.TICKS_PER_SEC(1)) dut_fast (
    .clk(clk), .rst(rst), .run(run), .load(load), .ld_hrs(ld_hrs), .ld_min(ld_min),
    .ld_sec(ld_sec), .mode12(mode12), .alarm_en(alarm_en), .alm_hrs(alm_hrs),
    .alm_min(alm_min), .sec(sec1), .min(min1), .hrs(hrs1), .disp_hrs(disp1), .pm(pm1),
    .tick_1hz(tick1), .day_wrap(wrap1), .alarm(alarm1), .load_err(err1)
  );

  assign got0 = {hrs0, min0, sec0, disp0, pm0, tick0, wrap0, alarm0, err0};
  assign got1 = {hrs1, min1, sec1, disp1, pm1, tick1, wrap1, alarm1, err1};

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_tod[i] = 0; m_cnt[i] = 0;
      m_tick[i] = 0; m_wrap[i] = 0; m_alm[i] = 0; m_err[i] = 0;
    end
  endtask

  // Advance the model by one clock edge, using the inputs currently applied.
  task automatic model_step(int i);
    m_tick[i] = 0; m_wrap[i] = 0; m_alm[i] = 0;
    if (load) begin
      if (ld_hrs < 24 && ld_min < 60 && ld_sec < 60) begin
        m_tod[i] = int'(ld_hrs) * 3600 + int'(ld_min) * 60 + int'(ld_sec);
        m_cnt[i] = 0;
        m_err[i] = 0;
      end else begin
        m_err[i] = 1;
      end
    end else if (run) begin
      if (m_cnt[i] == tps[i] - 1) begin
        m_cnt[i]  = 0;
        m_tod[i]  = (m_tod[i] + 1) % 86400;
        m_tick[i] = 1;
        m_wrap[i] = (m_tod[i] == 0);
        m_alm[i]  = alarm_en && (m_tod[i] / 3600 == int'(alm_hrs)) &&
                    ((m_tod[i] / 60) % 60 == int'(alm_min)) && (m_tod[i] % 60 == 0);
      end else begin
        m_cnt[i]++;
      end
    end
  endtask

  function automatic logic [26:0] exp_vec(int i);
    int h, m, s;
    logic [4:0] d;
    logic p;
    h = m_tod[i] / 3600;
    m = (m_tod[i] / 60) % 60;
    s = m_tod[i] % 60;
    if (mode12) begin
      d = (h % 12 == 0) ? 5'd12 : 5'(h % 12);
      p = (h >= 12);
    end else begin
      d = 5'(h);
      p = 1'b0;
    end
    return {5'(h), 6'(m), 6'(s), d, p, m_tick[i], m_wrap[i], m_alm[i], m_err[i]};
  endfunction

  // One clock: update the model, then wait until just after the rising edge.
  task automatic cycle();
    for (int i = 0; i < 2; i++) model_step(i);
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(int h, int m, int s);
    load = 1'b1; ld_hrs = 5'(h); ld_min = 6'(m); ld_sec = 6'(s);
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; load = 1'b0; mode12 = 1'b1; alarm_en = 1'b0;
    ld_hrs = '0; ld_min = '0; ld_sec = '0; alm_hrs = 5'd31; alm_min = 6'd63;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({sec0, min0, hrs0, disp0, pm0, tick0, wrap0, alarm0, err0} !==
        {6'd0, 6'd0, 5'd0, 5'd12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("[TB] FAIL reset_state: got %h required hrs=0 min=0 sec=0 disp=12 others 0", got0);
    end
    rst = 1'b0;
    mode12 = 1'b0;
  endtask

  task automatic test_run_count();
    int nticks, held, wait_cyc;
    nticks = 0;
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cycle();
      nticks += int'(tick0);
      checks++;
      if (got0 !== exp_vec(0)) begin
        errors++;
        $display("[TB] FAIL run_count cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
    end
    checks++;
    if (nticks != 10) begin
      errors++;
      $display("[TB] FAIL run_tick_count: got %0d required 10", nticks);
    end
    repeat (2) cycle();
    held = m_cnt[0];
    run = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (got0 !== exp_vec(0) || tick0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL run_frozen cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
    end
    run = 1'b1;
    wait_cyc = 0;
    for (int k = 1; k <= 8 && wait_cyc == 0; k++) begin
      cycle();
      if (tick0 === 1'b1) wait_cyc = k;
    end
    checks++;
    if (wait_cyc != 4 - held) begin
      errors++;
      $display("[TB] FAIL resume_latency: got %0d cycles required %0d", wait_cyc, 4 - held);
    end
    for (int k = 0; k < 60; k++) begin
      run = ($urandom_range(0, 3) != 0);
      mode12 = $urandom_range(0, 1) == 1;
      cycle();
      checks++;
      if (got0 !== exp_vec(0)) begin
        errors++;
        $display("[TB] FAIL run_random cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
    end
  endtask

  task automatic test_rollover();
    run = 1'b1;
    set_load(23, 59, 58);
    cycle();
    load = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cycle();
      checks++;
      if (got0 !== exp_vec(0)) begin
        errors++;
        $display("[TB] FAIL rollover cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
      if (k == 4) begin
        checks++;
        if ({hrs0, min0, sec0, tick0} !== {5'd23, 6'd59, 6'd59, 1'b1}) begin
          errors++;
          $display("[TB] FAIL rollover_235959: got %0d:%0d:%0d tick=%b required 23:59:59 tick=1",
                   hrs0, min0, sec0, tick0);
        end
      end
    end
    checks++;
    if ({hrs0, min0, sec0, tick0, wrap0} !== {5'd0, 6'd0, 6'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("[TB] FAIL day_wrap: got %0d:%0d:%0d tick=%b wrap=%b required 0:0:0 tick=1 wrap=1",
               hrs0, min0, sec0, tick0, wrap0);
    end
  endtask

  task automatic test_load();
    run = 1'b0;
    set_load(24, 0, 0);
    cycle();
    load = 1'b0;
    checks++;
    if (err0 !== 1'b1 || got0 !== exp_vec(0)) begin
      errors++;
      $display("[TB] FAIL load_invalid: got err=%b vec %h required err=1 vec %h", err0, got0, exp_vec(0));
    end
    set_load(12, 34, 56);
    cycle();
    load = 1'b0;
    checks++;
    if ({err0, hrs0, min0, sec0} !== {1'b0, 5'd12, 6'd34, 6'd56}) begin
      errors++;
      $display("[TB] FAIL load_valid: got err=%b %0d:%0d:%0d required err=0 12:34:56",
               err0, hrs0, min0, sec0);
    end
    run = 1'b1;
    for (int k = 0; k < 8 && m_cnt[0] != 3; k++) cycle();
    set_load(1, 2, 3);
    cycle();
    load = 1'b0;
    checks++;
    if ({tick0, hrs0, min0, sec0} !== {1'b0, 5'd1, 6'd2, 6'd3}) begin
      errors++;
      $display("[TB] FAIL load_on_wrap: got tick=%b %0d:%0d:%0d required tick=0 1:2:3",
               tick0, hrs0, min0, sec0);
    end
    for (int k = 0; k < 50; k++) begin
      run = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 2) == 0)
        set_load($urandom_range(0, 26), $urandom_range(0, 63), $urandom_range(0, 63));
      else
        load = 1'b0;
      cycle();
      checks++;
      if (got0 !== exp_vec(0)) begin
        errors++;
        $display("[TB] FAIL load_random cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_12h();
    int hv [5] = '{0, 11, 12, 13, 23};
    int dv [5] = '{12, 11, 12, 1, 11};
    int pv [5] = '{0, 0, 1, 1, 1};
    run = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_load(hv[k], 15, 0);
      cycle();
      load = 1'b0;
      mode12 = 1'b1;
      #1;
      checks++;
      if (disp0 !== 5'(dv[k]) || pm0 !== 1'(pv[k])) begin
        errors++;
        $display("[TB] FAIL mode12 hrs %0d: got disp=%0d pm=%b required disp=%0d pm=%0d",
                 hv[k], disp0, pm0, dv[k], pv[k]);
      end
      mode12 = 1'b0;
      #1;
      checks++;
      if (disp0 !== 5'(hv[k]) || pm0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL mode24 hrs %0d: got disp=%0d pm=%b required disp=%0d pm=0",
                 hv[k], disp0, pm0, hv[k]);
      end
    end
  endtask

  task automatic test_alarm();
    int pulses;
    alm_hrs = 5'd7; alm_min = 6'd30;
    for (int en = 1; en >= 0; en--) begin
      alarm_en = 1'(en);
      run = 1'b1;
      set_load(7, 29, 59);
      cycle();
      load = 1'b0;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
        cycle();
        pulses += int'(alarm0);
        checks++;
        if (got0 !== exp_vec(0)) begin
          errors++;
          $display("[TB] FAIL alarm_seq en=%0d cyc %0d: got %h required %h", en, k, got0, exp_vec(0));
        end
      end
      checks++;
      if (pulses != en) begin
        errors++;
        $display("[TB] FAIL alarm_pulses en=%0d: got %0d required %0d", en, pulses, en);
      end
    end
    run = 1'b0;
    alarm_en = 1'b1;
    set_load(7, 30, 0);
    cycle();
    load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      alarm_en = ~alarm_en;
      alm_min = (k == 2) ? 6'd31 : 6'd30;
      cycle();
      checks++;
      if (alarm0 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL alarm_no_tick cyc %0d: got %b required 0", k, alarm0);
      end
    end
    run = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (k % 10 == 0) begin
        alarm_en = $urandom_range(0, 3) != 0;
        alm_hrs = 5'($urandom_range(0, 25));
        alm_min = 6'($urandom_range(0, 63));
        set_load(alm_hrs > 23 ? 5 : int'(alm_hrs), alm_min > 59 ? 0 : int'(alm_min), 0);
        ld_sec = 6'd0;
        if (ld_min == 6'd0) begin
          ld_min = 6'd0;
        end else begin
          ld_min = ld_min - 6'd1;
          ld_sec = 6'd59;
        end
      end else begin
        load = 1'b0;
      end
      cycle();
      checks++;
      if (got0 !== exp_vec(0)) begin
        errors++;
        $display("[TB] FAIL alarm_random cyc %0d: got %h required %h", k, got0, exp_vec(0));
      end
    end
    load = 1'b0;
  endtask

  task automatic test_async_reset();
    run = 1'b1;
    mode12 = 1'b1;
    set_load(10, 20, 30);
    cycle();
    load = 1'b0;
    repeat (6) cycle();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if ({sec0, min0, hrs0, tick0, wrap0, alarm0, err0, disp0, pm0} !==
        {6'd0, 6'd0, 5'd0, 4'd0, 5'd12, 1'b0}) begin
      errors++;
      $display("[TB] FAIL async_reset: got %h required zero time with disp=12", got0);
    end
    checks++;
    if (got1 !== exp_vec(1)) begin
      errors++;
      $display("[TB] FAIL async_reset_fast: got %h required %h", got1, exp_vec(1));
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    mode12 = 1'b0;
  endtask

  task automatic test_fast();
    run = 1'b1;
    set_load(0, 0, 0);
    cycle();
    load = 1'b0;
    for (int k = 0; k < 70; k++) begin
      cycle();
      checks++;
      if (sec1 !== 6'((k + 1) % 60) || tick1 !== 1'b1 || got1 !== exp_vec(1)) begin
        errors++;
        $display("[TB] FAIL fast_tick cyc %0d: got %h required %h sec %0d", k, got1, exp_vec(1),
                 (k + 1) % 60);
      end
    end
  endtask

  initial begin
    test_reset();
    test_run_count();
    test_rollover();
    test_load();
    test_12h();
    test_alarm();
    test_async_reset();
    test_fast();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
